sdspi_host_arbiter: RTL and testbench
=====================================

Name: sdspi_host_arbiter

Overview:
Shares one sdspihost command/data interface between N_REQ requesters, e.g. the autotest sequencer (index 0) and the UUT datapath (index 1). Ownership is granted per session: one reset, one single-block read, one multi-block read or one block write. Grants use round-robin arbitration with a hold watchdog. The arbiter sits between the requesters and sdspihost and replaces the static uut_ctrl_mux steering.

Parameters:
N_REQ, 2, number of requesters (2..4); index 0 has initial priority.
MAX_HOLD, 32'h0800_0000, maximum clk cycles one grant may last before forced release.
GAP_CYCLES, 2, idle cycles driven to the host between two grants (>=1).

Ports:
clk  in  1  clock.
rst  in  1  reset; synchronous, active-high.
req_rst  in  N_REQ  per-requester SD init request.
req_r_block  in  N_REQ  per-requester single-block read session strobe.
req_r_multi_block  in  N_REQ  per-requester multi-block read session strobe.
req_w_block  in  N_REQ  per-requester block write session strobe.
req_r_byte  in  N_REQ  per-requester byte read strobe.
req_w_byte  in  N_REQ  per-requester byte write strobe.
req_block_addr  in  32*N_REQ  per-requester block address; requester i uses bits [32i+31:32i].
req_data_in  in  8*N_REQ  per-requester write byte.
req_busy  out  N_REQ  busy seen by each requester.
req_data_out  out  8  host read byte, broadcast to all requesters.
req_err  out  N_REQ  host err routed to the owner.
req_crc_err  out  N_REQ  host crc_err routed to the owner.
spi_rst, spi_r_block, spi_r_multi_block, spi_w_block, spi_r_byte, spi_w_byte  out  1 each  strobes to the host.
spi_block_addr  out  32  address to the host.
spi_data_in  out  8  write byte to the host.
spi_busy, spi_err, spi_crc_err  in  1 each  host status.
spi_data_out  in  8  host read byte.
grant  out  N_REQ  one-hot owner; all zero when there is no owner.
timeout_err  out  1  one-cycle pulse on a forced release.
hold_count  out  32  cycles elapsed in the current grant (debug).

Behaviour:
- Session request, per requester: sreq[i] = req_rst | req_r_block | req_r_multi_block | req_w_block.
- Reset values:
  - State is IDLE; grant = 0; rr_ptr = 0; hold_count = 0; timeout_err = 0.
  - All spi_* strobes = 0; spi_block_addr = 0; spi_data_in = 8'hFF.
  - req_busy = all ones; req_err = 0; req_crc_err = 0.
- Reset mid-session: the host strobes drop in the same cycle that rst is sampled. No handshake with the host is attempted.
- IDLE:
  - If any sreq is set, pick the first requester set at or after rr_ptr, searching cyclically.
  - Register grant one-hot and go to OWNED next cycle. Arbitration latency is exactly 1 cycle.
  - If no sreq is set, stay in IDLE.
- Simultaneous requests are resolved purely by rr_ptr. No requester is ever granted twice while another is waiting.
- OWNED (owner k):
  - All spi_* strobes, spi_block_addr and spi_data_in come combinationally from requester k's inputs.
  - req_busy[k] = spi_busy; req_err[k] = spi_err; req_crc_err[k] = spi_crc_err.
  - Every other requester sees req_busy = 1, req_err = 0 and req_crc_err = 0.
  - Byte strobes from non-owners are ignored.
  - hold_count increments every cycle.
  - When sreq[k] = 0, go to DRAIN.
  - When hold_count reaches MAX_HOLD-1, go to DRAIN and pulse timeout_err for 1 cycle.
- DRAIN:
  - All spi_* strobes = 0, and spi_data_in returns to 8'hFF.
  - Owner busy remains mirrored from spi_busy.
  - When spi_busy = 0, go to GAP.
- GAP:
  - Lasts GAP_CYCLES cycles, using an internal counter.
  - On entry, grant clears and rr_ptr = (k+1) mod N_REQ.
  - All req_busy = 1; hold_count = 0.
  - Then go to IDLE.
- A requester whose sreq is still high after a forced release is simply re-arbitrated. Its strobes must be dropped and re-raised by that requester for a fresh session; the arbiter does not track this.
- Outputs to the host never carry strobes from two requesters in the same cycle.

Test Plan:
1. Only req 0 raises req_r_block; host busy for 10 cycles, then 512 byte cycles; req 0 drops the strobe -> grant = 01 one cycle later; spi_r_block follows req 0; req_busy[1] = 1 throughout; after DRAIN, grant = 00 for GAP_CYCLES = 2 cycles.
2. Both requesters raise sreq in the same cycle from reset -> grant = 01 first, and req 1 is granted immediately after req 0's GAP. Repeat with rr_ptr = 1 -> req 1 is granted first.
3. Owner 1 issues req_w_byte with req_data_in[15:8] = 8'h5A while req 0 pulses req_w_byte with 8'h11 -> spi_w_byte and spi_data_in = 8'h5A only; req 0 is ignored.
4. MAX_HOLD = 16 and req 0 holds req_r_multi_block forever -> timeout_err pulses at hold_count = 15; strobes drop; grant moves to req 1 when it is requesting.
5. Owner drops its strobe while spi_busy = 1 for 7 more cycles -> state stays in DRAIN for 7 cycles, with no new grant until spi_busy = 0 plus GAP.
6. Assert rst during OWNED with spi_w_block high -> next cycle: all strobes 0, grant = 0, req_busy = all ones, spi_data_in = 8'hFF.

Source files
------------

// File: rtl/sdspi_host_arbiter.sv
// Round-robin, per-session arbiter sharing one sdspihost command/data port between N_REQ requesters.
// A grant lasts for one session, and a hold watchdog forces release of a grant that runs too long.
module sdspi_host_arbiter #(
    parameter int unsigned N_REQ      = 2,
    parameter logic [31:0] MAX_HOLD   = 32'h0800_0000,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_rst,
    input  logic [N_REQ-1:0]     req_r_block,
    input  logic [N_REQ-1:0]     req_r_multi_block,
    input  logic [N_REQ-1:0]     req_w_block,
    input  logic [N_REQ-1:0]     req_r_byte,
    input  logic [N_REQ-1:0]     req_w_byte,
    input  logic [32*N_REQ-1:0]  req_block_addr,
    input  logic [8*N_REQ-1:0]   req_data_in,
    output logic [N_REQ-1:0]     req_busy,
    output logic [7:0]           req_data_out,
    output logic [N_REQ-1:0]     req_err,
    output logic [N_REQ-1:0]     req_crc_err,
    output logic                 spi_rst,
    output logic                 spi_r_block,
    output logic                 spi_r_multi_block,
    output logic                 spi_w_block,
    output logic                 spi_r_byte,
    output logic                 spi_w_byte,
    output logic [31:0]          spi_block_addr,
    output logic [7:0]           spi_data_in,
    input  logic                 spi_busy,
    input  logic                 spi_err,
    input  logic                 spi_crc_err,
    input  logic [7:0]           spi_data_out,
    output logic [N_REQ-1:0]     grant,
    output logic                 timeout_err,
    output logic [31:0]          hold_count
);

    typedef enum logic [1:0] {StIdle, StOwned, StDrain, StGap} state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [31:0]       hold_q, hold_d;
    logic [31:0]       gap_q, gap_d;

    logic [N_REQ-1:0]  sreq;
    logic [3:0]        sreq_pad;
    logic [1:0]        cand;
    logic [1:0]        pick_idx;
    logic              pick_found;
    logic [1:0]        own_idx;
    logic              own_sreq;

    assign sreq     = req_rst | req_r_block | req_r_multi_block | req_w_block;
    assign own_sreq = |(sreq & grant_q);

    // Cyclic search starting at rr_ptr; the 4-bit pad keeps indexing in range for any N_REQ.
    always_comb begin
        sreq_pad              = '0;
        sreq_pad[N_REQ-1:0]   = sreq;
        cand                  = '0;
        pick_idx              = '0;
        pick_found            = 1'b0;
        for (int o = 0; o < int'(N_REQ); o++) begin
            cand = 2'((32'(rr_ptr_q) + 32'(o)) % N_REQ);
            if (!pick_found && sreq_pad[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        own_idx = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant_q[i]) own_idx = 2'(i);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            hold_q   <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
            gap_q    <= gap_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        gap_d    = gap_q;
        unique case (state_q)
            StIdle: begin
                hold_d = '0;
                if (pick_found) begin
                    grant_d = '0;
                    for (int i = 0; i < int'(N_REQ); i++) begin
                        if (pick_idx == 2'(i)) grant_d[i] = 1'b1;
                    end
                    state_d = StOwned;
                end
            end
            StOwned: begin
                hold_d = hold_q + 32'd1;
                if (!own_sreq || hold_q == MAX_HOLD - 32'd1) state_d = StDrain;
            end
            StDrain: begin
                if (!spi_busy) begin
                    state_d  = StGap;
                    grant_d  = '0;
                    hold_d   = '0;
                    gap_d    = '0;
                    rr_ptr_d = (own_idx == 2'(N_REQ - 1)) ? 2'd0 : own_idx + 2'd1;
                end
            end
            StGap: begin
                hold_d = '0;
                if (gap_q >= GAP_CYCLES - 1) state_d = StIdle;
                else gap_d = gap_q + 32'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        spi_rst           = 1'b0;
        spi_r_block       = 1'b0;
        spi_r_multi_block = 1'b0;
        spi_w_block       = 1'b0;
        spi_r_byte        = 1'b0;
        spi_w_byte        = 1'b0;
        spi_block_addr    = '0;
        spi_data_in       = 8'hFF;
        req_busy          = '1;
        req_err           = '0;
        req_crc_err       = '0;
        timeout_err       = 1'b0;
        unique case (state_q)
            StOwned: begin
                for (int i = 0; i < int'(N_REQ); i++) begin
                    if (grant_q[i]) begin
                        spi_rst           = req_rst[i];
                        spi_r_block       = req_r_block[i];
                        spi_r_multi_block = req_r_multi_block[i];
                        spi_w_block       = req_w_block[i];
                        spi_r_byte        = req_r_byte[i];
                        spi_w_byte        = req_w_byte[i];
                        spi_block_addr    = req_block_addr[32*i +: 32];
                        spi_data_in       = req_data_in[8*i +: 8];
                        req_busy[i]       = spi_busy;
                        req_err[i]        = spi_err;
                        req_crc_err[i]    = spi_crc_err;
                    end
                end
                timeout_err = own_sreq && (hold_q == MAX_HOLD - 32'd1);
            end
            StDrain: begin
                for (int i = 0; i < int'(N_REQ); i++) begin
                    if (grant_q[i]) begin
                        req_busy[i]    = spi_busy;
                        req_err[i]     = spi_err;
                        req_crc_err[i] = spi_crc_err;
                    end
                end
            end
            default: ;
        endcase
        // Host strobes drop while rst is asserted, before the state register clears.
        if (rst) begin
            spi_rst           = 1'b0;
            spi_r_block       = 1'b0;
            spi_r_multi_block = 1'b0;
            spi_w_block       = 1'b0;
            spi_r_byte        = 1'b0;
            spi_w_byte        = 1'b0;
            spi_block_addr    = '0;
            spi_data_in       = 8'hFF;
            timeout_err       = 1'b0;
        end
    end

    assign req_data_out = spi_data_out;
    assign grant        = grant_q;
    assign hold_count   = hold_q;

endmodule

// File: tb/tb_sdspi_host_arbiter.sv
// Directed bench for sdspi_host_arbiter: N_REQ=2, MAX_HOLD=16, GAP_CYCLES=2.
module tb_sdspi_host_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_rst, req_r_block, req_r_multi_block, req_w_block, req_r_byte, req_w_byte;
    logic [63:0] req_block_addr;
    logic [15:0] req_data_in;
    logic [1:0]  req_busy, req_err, req_crc_err;
    logic [7:0]  req_data_out;
    logic        spi_rst, spi_r_block, spi_r_multi_block, spi_w_block, spi_r_byte, spi_w_byte;
    logic [31:0] spi_block_addr;
    logic [7:0]  spi_data_in;
    logic        spi_busy, spi_err, spi_crc_err;
    logic [7:0]  spi_data_out;
    logic [1:0]  grant;
    logic        timeout_err;
    logic [31:0] hold_count;

    int tests = 0;
    int fails = 0;

    sdspi_host_arbiter #(
        .N_REQ     (2),
        .MAX_HOLD  (32'd16),
        .GAP_CYCLES(2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_rst          (req_rst),
        .req_r_block      (req_r_block),
        .req_r_multi_block(req_r_multi_block),
        .req_w_block      (req_w_block),
        .req_r_byte       (req_r_byte),
        .req_w_byte       (req_w_byte),
        .req_block_addr   (req_block_addr),
        .req_data_in      (req_data_in),
        .req_busy         (req_busy),
        .req_data_out     (req_data_out),
        .req_err          (req_err),
        .req_crc_err      (req_crc_err),
        .spi_rst          (spi_rst),
        .spi_r_block      (spi_r_block),
        .spi_r_multi_block(spi_r_multi_block),
        .spi_w_block      (spi_w_block),
        .spi_r_byte       (spi_r_byte),
        .spi_w_byte       (spi_w_byte),
        .spi_block_addr   (spi_block_addr),
        .spi_data_in      (spi_data_in),
        .spi_busy         (spi_busy),
        .spi_err          (spi_err),
        .spi_crc_err      (spi_crc_err),
        .spi_data_out     (spi_data_out),
        .grant            (grant),
        .timeout_err      (timeout_err),
        .hold_count       (hold_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_rst = '0; req_r_block = '0; req_r_multi_block = '0; req_w_block = '0;
        req_r_byte = '0; req_w_byte = '0;
        req_block_addr = {32'hBBBB_0001, 32'hAAAA_0000};
        req_data_in = 16'h0000;
        spi_busy = 1'b0; spi_err = 1'b0; spi_crc_err = 1'b0; spi_data_out = 8'h00;
        tick();
        tick();
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_busy", 64'(req_busy), 64'h3);
        chk("rst_data_in", 64'(spi_data_in), 64'hFF);
        chk("rst_hold", 64'(hold_count), 64'h0);
        chk("rst_timeout", 64'(timeout_err), 64'h0);
        chk("rst_err", 64'({req_err, req_crc_err}), 64'h0);
        rst = 1'b0;
        tick();

        // Single requester, single-block read
        req_r_block = 2'b01;
        chk("t1_no_grant_yet", 64'(grant), 64'h0);
        tick();
        chk("t1_grant", 64'(grant), 64'h1);
        chk("t1_spi_r_block", 64'(spi_r_block), 64'h1);
        chk("t1_addr", 64'(spi_block_addr), 64'hAAAA_0000);
        chk("t1_hold0", 64'(hold_count), 64'h0);
        spi_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t1_busy_other", 64'(req_busy[1]), 64'h1);
        end
        chk("t1_hold10", 64'(hold_count), 64'd10);
        chk("t1_busy_mirror", 64'(req_busy), 64'h3);
        spi_busy = 1'b0;
        req_r_byte = 2'b01;
        spi_data_out = 8'hA5;
        #1;
        chk("t1_busy_mirror0", 64'(req_busy), 64'h2);
        chk("t1_r_byte", 64'(spi_r_byte), 64'h1);
        chk("t1_data_out", 64'(req_data_out), 64'hA5);
        tick();
        req_r_byte = 2'b00;
        req_r_block = 2'b00;
        tick();
        chk("t1_drain_grant", 64'(grant), 64'h1);
        chk("t1_drain_strobe", 64'(spi_r_block), 64'h0);
        tick();
        chk("t1_gap1_grant", 64'(grant), 64'h0);
        chk("t1_gap1_busy", 64'(req_busy), 64'h3);
        chk("t1_gap1_hold", 64'(hold_count), 64'h0);
        tick();
        chk("t1_gap2_grant", 64'(grant), 64'h0);
        tick();

        // rr_ptr=1: both request, req 1 first; req 0 strobes are ignored
        req_r_block = 2'b01;
        req_w_block = 2'b10;
        tick();
        chk("t2b_grant", 64'(grant), 64'h2);
        chk("t2b_w_block", 64'(spi_w_block), 64'h1);
        chk("t2b_r_block_ign", 64'(spi_r_block), 64'h0);
        chk("t2b_addr", 64'(spi_block_addr), 64'hBBBB_0001);
        chk("t2b_busy0", 64'(req_busy[0]), 64'h1);
        req_w_byte = 2'b11;
        req_data_in = {8'h5A, 8'h11};
        spi_err = 1'b1;
        #1;
        chk("t3_w_byte", 64'(spi_w_byte), 64'h1);
        chk("t3_data_in", 64'(spi_data_in), 64'h5A);
        chk("t3_err_route", 64'(req_err), 64'h2);
        spi_err = 1'b0;
        req_w_byte = 2'b01;
        #1;
        chk("t3_w_byte_ign", 64'(spi_w_byte), 64'h0);
        req_w_byte = 2'b00;

        // Owner drops while host stays busy for 7 cycles
        spi_busy = 1'b1;
        req_w_block = 2'b00;
        tick();
        chk("t5_data_in_ff", 64'(spi_data_in), 64'hFF);
        chk("t5_w_block0", 64'(spi_w_block), 64'h0);
        for (int i = 0; i < 7; i++) begin
            chk("t5_drain_grant", 64'(grant), 64'h2);
            chk("t5_drain_busy", 64'(req_busy), 64'h3);
            if (i < 6) tick();
        end
        spi_busy = 1'b0;
        tick();
        chk("t5_gap1", 64'(grant), 64'h0);
        tick();
        chk("t5_gap2", 64'(grant), 64'h0);
        tick();
        chk("t5_idle", 64'(grant), 64'h0);
        tick();
        chk("t5_next_grant", 64'(grant), 64'h1);
        req_r_block = 2'b00;
        tick(); tick(); tick(); tick();

        // Fresh reset, simultaneous requests: 0 then 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_r_block = 2'b11;
        tick();
        chk("t2a_first", 64'(grant), 64'h1);
        req_r_block = 2'b10;
        tick(); tick(); tick(); tick();
        chk("t2a_idle", 64'(grant), 64'h0);
        tick();
        chk("t2a_second", 64'(grant), 64'h2);
        req_r_block = 2'b00;
        tick(); tick(); tick(); tick();
        chk("t2a_done", 64'(grant), 64'h0);

        // Watchdog with MAX_HOLD=16
        req_r_multi_block = 2'b01;
        tick();
        chk("t4_grant", 64'(grant), 64'h1);
        req_rst = 2'b10;
        for (int i = 0; i < 14; i++) tick();
        chk("t4_hold14", 64'(hold_count), 64'd14);
        chk("t4_no_timeout", 64'(timeout_err), 64'h0);
        tick();
        chk("t4_hold15", 64'(hold_count), 64'd15);
        chk("t4_timeout", 64'(timeout_err), 64'h1);
        chk("t4_strobe_live", 64'(spi_r_multi_block), 64'h1);
        tick();
        chk("t4_strobe_drop", 64'(spi_r_multi_block), 64'h0);
        chk("t4_timeout_pulse", 64'(timeout_err), 64'h0);
        tick(); tick(); tick(); tick();
        chk("t4_grant_moves", 64'(grant), 64'h2);
        chk("t4_spi_rst", 64'(spi_rst), 64'h1);

        // Reset during OWNED with write block high
        req_w_block = 2'b10;
        #1;
        chk("t6_w_block_live", 64'(spi_w_block), 64'h1);
        rst = 1'b1;
        #1;
        chk("t6_same_cycle", 64'(spi_w_block), 64'h0);
        tick();
        chk("t6_strobes", 64'({spi_rst, spi_r_block, spi_r_multi_block, spi_w_block,
                               spi_r_byte, spi_w_byte}), 64'h0);
        chk("t6_grant", 64'(grant), 64'h0);
        chk("t6_busy", 64'(req_busy), 64'h3);
        chk("t6_data_in", 64'(spi_data_in), 64'hFF);
        rst = 1'b0;
        req_rst = '0; req_r_multi_block = '0; req_w_block = '0;
        tick();
        chk("t6_after_grant", 64'(grant), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
